// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light system: request-conditioner FSM
// state encoding, light codes used by the light controller, and a width helper.
package traffic_pkg;

   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_ARMED   = 2'b01;
   localparam logic [1:0] S_REQ     = 2'b10;
   localparam logic [1:0] S_RELEASE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = S_IDLE,
      ST_ARMED   = S_ARMED,
      ST_REQ     = S_REQ,
      ST_RELEASE = S_RELEASE
   } req_state_t;

   localparam logic [1:0] LIGHT_GREEN  = 2'b00;
   localparam logic [1:0] LIGHT_YELLOW = 2'b01;
   localparam logic [1:0] LIGHT_RED    = 2'b10;

   // Bits needed to hold values 0..v-1, never less than one bit.
   function automatic int clog2f(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/traffic_req_gen_tick_gen.sv
// Prescaler for the request conditioner: free-running 0..TICK_DIV-1 counter
// whose terminal count is the one-cycle timing strobe.
module traffic_tick_gen
   import traffic_pkg::*;
#(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = clog2f(TICK_DIV);
   localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = (r_cnt == C_LAST);

endmodule

// File: rtl/traffic_req_gen.sv
// Side-road vehicle request conditioner: sync, tick-sampled debounce, and
// wait/hold/extension FSM driving car_req. Optional TRAFFIC_PED_BTN_EN adds ped_btn.
module traffic_req_gen
   import traffic_pkg::*;
#(
   parameter int TICK_DIV  = 4,
   parameter int DEB_TICKS = 3,
   parameter int MIN_WAIT  = 2,
   parameter int MIN_HOLD  = 4,
   parameter int EXT_TICKS = 2,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sensor_raw,
`ifdef TRAFFIC_PED_BTN_EN
   input  logic             ped_btn,
`endif
   output logic             car_req,
   output logic             tick,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] req_count
);

   localparam int TMAX  = (MIN_WAIT > MIN_HOLD)
                        ? ((MIN_WAIT > EXT_TICKS) ? MIN_WAIT : EXT_TICKS)
                        : ((MIN_HOLD > EXT_TICKS) ? MIN_HOLD : EXT_TICKS);
   localparam int TMR_W = clog2f(TMAX + 1);
   localparam int DEB_W = clog2f(DEB_TICKS);

   localparam logic [TMR_W-1:0] C_WAIT_LAST = TMR_W'(MIN_WAIT - 1);
   localparam logic [TMR_W-1:0] C_HOLD      = TMR_W'(MIN_HOLD);
   localparam logic [TMR_W-1:0] C_EXT_LAST  = TMR_W'(EXT_TICKS - 1);
   localparam logic [DEB_W-1:0] C_DEB_LAST  = DEB_W'(DEB_TICKS - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic             w_tick;
   logic             r_sync_p0;
   logic             r_sync_p1;
   logic             r_stable;
   logic [DEB_W-1:0] r_deb_cnt;
   logic [TMR_W-1:0] r_timer;
   logic [CNT_W-1:0] r_req_count;
   req_state_t       r_state;
   logic             w_ped_go;

   traffic_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // Stage p0/p1: two-flop synchroniser for the asynchronous loop sensor
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync_p0 <= 1'b0;
         r_sync_p1 <= 1'b0;
      end else begin
         r_sync_p0 <= sensor_raw;
         r_sync_p1 <= r_sync_p0;
      end
   end

   // Debounce: level flips only after DEB_TICKS consecutive differing tick samples
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stable  <= 1'b0;
         r_deb_cnt <= '0;
      end else if (w_tick) begin
         if (r_sync_p1 == r_stable) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt == C_DEB_LAST) begin
            r_stable  <= r_sync_p1;
            r_deb_cnt <= '0;
         end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
         end
      end
   end

`ifdef TRAFFIC_PED_BTN_EN
   logic r_ped_pend;

   // A new pulse wins over a same-cycle consume so no press is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ped_pend <= 1'b0;
      end else if (ped_btn) begin
         r_ped_pend <= 1'b1;
      end else if (w_tick && !r_state[1]) begin
         r_ped_pend <= 1'b0;
      end
   end

   assign w_ped_go = r_ped_pend;
`else
   assign w_ped_go = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_timer     <= '0;
         r_req_count <= '0;
      end else if (w_tick) begin
         case (r_state)
            ST_IDLE: begin
               if (w_ped_go) begin
                  r_state     <= ST_REQ;
                  r_timer     <= '0;
                  r_req_count <= sat_inc(r_req_count);
               end else if (r_stable) begin
                  r_state <= ST_ARMED;
                  r_timer <= '0;
               end
            end
            ST_ARMED: begin
               if (w_ped_go) begin
                  r_state     <= ST_REQ;
                  r_timer     <= '0;
                  r_req_count <= sat_inc(r_req_count);
               end else if (!r_stable) begin
                  r_state <= ST_IDLE;
               end else if (r_timer == C_WAIT_LAST) begin
                  r_state     <= ST_REQ;
                  r_timer     <= '0;
                  r_req_count <= sat_inc(r_req_count);
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_REQ: begin
               if (!r_stable && (r_timer >= C_HOLD)) begin
                  r_state <= ST_RELEASE;
                  r_timer <= '0;
               end else if (r_timer != C_HOLD) begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: begin
               // Returning vehicle resumes the request with the hold already served.
               if (r_stable) begin
                  r_state <= ST_REQ;
                  r_timer <= C_HOLD;
               end else if (r_timer == C_EXT_LAST) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
         endcase
      end
   end

   // REQ and RELEASE share bit 1, so the decode cannot glitch between them.
   assign car_req   = r_state[1];
   assign tick      = w_tick;
   assign state_o   = r_state;
   assign req_count = r_req_count;

endmodule

// File: tb/tb_traffic_req_gen.sv
// Directed bench for traffic_req_gen: reset, tick phase, arrival, glitch,
// hold/extension, return in RELEASE, count saturation and mid-run reset.
module tb_traffic_req_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       sensor_raw;
   logic       car_req, tick;
   logic [1:0] state_o;
   logic [7:0] req_count;
   logic       s_car_req, s_tick;
   logic [1:0] s_state_o;
   logic [1:0] s_req_count;

   int n_checks = 0;
   int n_pass   = 0;
   int edges    = 0;

   always #5 clk = ~clk;

   traffic_req_gen u_dut (
      .clk        (clk),
      .rst        (rst),
      .sensor_raw (sensor_raw),
      .car_req    (car_req),
      .tick       (tick),
      .state_o    (state_o),
      .req_count  (req_count)
   );

   traffic_req_gen #(.CNT_W(2)) u_sat (
      .clk        (clk),
      .rst        (rst),
      .sensor_raw (sensor_raw),
      .car_req    (s_car_req),
      .tick       (s_tick),
      .state_o    (s_state_o),
      .req_count  (s_req_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edges - 1);
   endtask

   // Advance until edge k (0 = first edge after reset release) has happened, then settle.
   task automatic run_to(input int k);
      while (edges < k + 1) begin
         @(posedge clk);
         edges++;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sensor_raw = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      edges = 0;
   endtask

   task automatic wait_state(input string tag, input logic [1:0] st, input int limit);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < limit && !seen; n++) begin
         @(posedge clk);
         #1;
         if (state_o == st) seen = 1'b1;
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      logic ok;
      int   exp_sat;

      // Reset values while rst is held
      rst = 1'b1;
      sensor_raw = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_car_req", 32'(car_req), 32'd0);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_count", 32'(req_count), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_sat_count", 32'(s_req_count), 32'd0);

      // Tick phase: strobe consumed at edges 3, 7, 11
      rst = 1'b0;
      edges = 0;
      run_to(1);  chk("tick_e1", 32'(tick), 32'd0);
      run_to(2);  chk("tick_e2", 32'(tick), 32'd1);
      run_to(3);  chk("tick_e3", 32'(tick), 32'd0);
      run_to(6);  chk("tick_e6", 32'(tick), 32'd1);
      run_to(10); chk("tick_e10", 32'(tick), 32'd1);

      // Clean arrival, then leave one cycle after REQ entry
      do_reset();
      sensor_raw = 1'b1;
      run_to(14); chk("arr_idle_e14", 32'(state_o), 32'd0);
      run_to(15); chk("arr_armed_e15", 32'(state_o), 32'd1);
      run_to(22); chk("arr_armed_e22", 32'(state_o), 32'd1);
      chk("arr_car_e22", 32'(car_req), 32'd0);
      run_to(23); chk("arr_req_e23", 32'(state_o), 32'd2);
      chk("arr_car_e23", 32'(car_req), 32'd1);
      chk("arr_count_e23", 32'(req_count), 32'd1);
      run_to(24);
      sensor_raw = 1'b0;
      run_to(42); chk("hold_req_e42", 32'(state_o), 32'd2);
      chk("hold_car_e42", 32'(car_req), 32'd1);
      run_to(43); chk("hold_rel_e43", 32'(state_o), 32'd3);
      chk("hold_car_e43", 32'(car_req), 32'd1);
      run_to(50); chk("ext_rel_e50", 32'(state_o), 32'd3);
      run_to(51); chk("ext_idle_e51", 32'(state_o), 32'd0);
      chk("ext_car_e51", 32'(car_req), 32'd0);
      chk("ext_count_e51", 32'(req_count), 32'd1);

      // Glitch: high for two tick samples only
      do_reset();
      sensor_raw = 1'b1;
      run_to(5);
      sensor_raw = 1'b0;
      ok = 1'b1;
      for (int k = 6; k <= 80; k++) begin
         run_to(k);
         if (state_o != 2'b00 || car_req != 1'b0) ok = 1'b0;
      end
      chk("glitch_quiet", 32'(ok), 32'd1);
      chk("glitch_count", 32'(req_count), 32'd0);

      // Return while in RELEASE
      do_reset();
      sensor_raw = 1'b1;
      run_to(23); chk("ret_req_e23", 32'(state_o), 32'd2);
      run_to(24);
      sensor_raw = 1'b0;
      run_to(36);
      sensor_raw = 1'b1;
      ok = 1'b1;
      for (int k = 37; k <= 60; k++) begin
         run_to(k);
         if (car_req != 1'b1) ok = 1'b0;
         if (k == 43) chk("ret_rel_e43", 32'(state_o), 32'd3);
         if (k == 47) chk("ret_rel_e47", 32'(state_o), 32'd3);
         if (k == 51) chk("ret_req_e51", 32'(state_o), 32'd2);
      end
      chk("ret_car_steady", 32'(ok), 32'd1);
      chk("ret_state_e60", 32'(state_o), 32'd2);
      chk("ret_count", 32'(req_count), 32'd1);

      // Five separate requests: 8-bit counts to 5, 2-bit saturates at 3
      do_reset();
      for (int i = 0; i < 5; i++) begin
         sensor_raw = 1'b1;
         wait_state("sat_reach_req", 2'b10, 100);
         exp_sat = (i + 1 > 3) ? 3 : i + 1;
         chk("sat_count_main", 32'(req_count), 32'(i + 1));
         chk("sat_count_2b", 32'(s_req_count), 32'(exp_sat));
         sensor_raw = 1'b0;
         wait_state("sat_reach_idle", 2'b00, 100);
      end
      chk("sat_final_2b", 32'(s_req_count), 32'd3);

      // Mid-run reset while in REQ
      sensor_raw = 1'b1;
      wait_state("mid_reach_req", 2'b10, 100);
      chk("mid_car_before", 32'(car_req), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_car", 32'(car_req), 32'd0);
      chk("mid_rst_state", 32'(state_o), 32'd0);
      chk("mid_rst_count", 32'(req_count), 32'd0);
      chk("mid_rst_sat", 32'(s_req_count), 32'd0);
      chk("mid_rst_tick", 32'(tick), 32'd0);
      rst = 1'b0;
      sensor_raw = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
